instr_encoder: RTL

//  Converts RV32I instruction fields plus a 32-bit signed immediate into a 32-bit machine word.
//  It is the inverse of imm_gen's immediate extraction.

---
 rtl/instr_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage RV32I instruction encoder (fields + immediate -> machine word)
//
// Purpose: stage 1 registers the instruction fields together with the
// immediate range/alignment verdict; stage 2 packs the registered fields
// into the 32-bit word. Valid/ready handshake on both sides, one
// instruction per cycle when the consumer keeps out_ready high.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   input handshake
//   fmt                   0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, rd, rs1, rs2  instruction fields
//   funct3, funct7        instruction fields
//   imm32                 signed immediate (byte offset for B/J)
//   out_valid / out_ready output handshake
//   instr, err            encoded word and range/alignment/format error

module instr_encoder #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_opcode_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [31:0] s1_imm_q;
  logic        s1_err_q;

  logic        advance;
  logic        in_fire;
  logic        chk_err;
  logic [31:0] pack;
  logic signed [31:0] imm_s;

  // s2 empties or drains this cycle; s1 moves forward under the same condition.
  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign imm_s    = imm32;

  // Range/alignment verdict on the incoming immediate.
  always_comb begin
    chk_err = 1'b0;
    case (fmt)
      FMT_R:        chk_err = 1'b0;
      FMT_I, FMT_S: chk_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      FMT_B:        chk_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm32[0];
      FMT_J:        chk_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm32[0];
      FMT_U:        chk_err = |imm32[11:0];
      default:      chk_err = 1'b1;
    endcase
  end

  // Bit packing from the stage-1 registers; fields a format does not use never appear.
  always_comb begin
    pack = 32'h0000_0000;
    case (s1_fmt_q)
      FMT_R: pack = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_I: pack = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_S: pack = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0], s1_opcode_q};
      FMT_B: pack = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                     s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      FMT_U: pack = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      FMT_J: pack = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                     s1_rd_q, s1_opcode_q};
      default: pack = 32'h0000_0000;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    instr_d    = instr_q;
    err_d      = err_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
    if (advance) begin
      s2_valid_d = s1_valid_q;
      // Only overwrite the output word when a real entry moves in, so it stays quiet when idle.
      if (s1_valid_q) begin
        instr_d = pack;
        err_d   = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      instr_q    <= 32'h0000_0000;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
    end
  end

  // Stage-1 payload needs no reset: it is only observed behind s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_fmt_q    <= fmt;
      s1_opcode_q <= opcode;
      s1_rd_q     <= rd;
      s1_rs1_q    <= rs1;
      s1_rs2_q    <= rs2;
      s1_funct3_q <= funct3;
      s1_funct7_q <= funct7;
      s1_imm_q    <= imm32;
      s1_err_q    <= CHECK_EN && chk_err;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;

endmodule
